// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - shared types, constants and legal-K check for the 8b/10b encode controller
package enc8b10b_pkg;

  typedef logic [9:0] sym_t;

  typedef enum logic {SYNC, RUN} state_t;

  localparam logic [7:0] K28_5 = 8'hBC;

  // K28.y for every y, plus the four K.x.7 codes with x != 28
  function automatic logic k_legal(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/enc8b10b_ctrl_if.sv
// rtl/enc8b10b_ctrl_if.sv - byte-in / symbol-out stream bundle of the 8b/10b encode controller
interface enc8b10b_ctrl_if;
  import enc8b10b_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_k;
  logic       out_valid;
  logic       out_ready;
  sym_t       out_data;
  logic       out_rd;
  logic       code_err;

  modport master (
    output in_valid, in_data, in_k, out_ready,
    input  in_ready, out_valid, out_data, out_rd, code_err
  );

  modport slave (
    input  in_valid, in_data, in_k, out_ready,
    output in_ready, out_valid, out_data, out_rd, code_err
  );

endinterface

// File: rtl/enc8b10b_sym.sv
// rtl/enc8b10b_sym.sv - combinational 8b/10b symbol encoder; illegal K requests become K28.5
module enc8b10b_sym
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output sym_t       code,
  output logic       rd_out,
  output logic       k_illegal
);

  logic [7:0] eff_data;
  logic       eff_k;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six_neg, six;
  logic [3:0] four_neg, four;
  logic       six_bal, four_bal, rd_mid, alt7;

  always_comb begin
    eff_data  = data;
    eff_k     = k;
    k_illegal = 1'b0;
    if (k && !k_legal(data)) begin
      eff_data  = K28_5;
      k_illegal = 1'b1;
    end
  end

  assign x = eff_data[4:0];
  assign y = eff_data[7:5];

  // 5b/6b codes in their RD- form (abcdei); RD+ is the complement where the code is unbalanced
  always_comb begin
    six_neg = 6'b000000;
    case (x)
      5'd0:  six_neg = 6'b100111;
      5'd1:  six_neg = 6'b011101;
      5'd2:  six_neg = 6'b101101;
      5'd3:  six_neg = 6'b110001;
      5'd4:  six_neg = 6'b110101;
      5'd5:  six_neg = 6'b101001;
      5'd6:  six_neg = 6'b011001;
      5'd7:  six_neg = 6'b111000;
      5'd8:  six_neg = 6'b111001;
      5'd9:  six_neg = 6'b100101;
      5'd10: six_neg = 6'b010101;
      5'd11: six_neg = 6'b110100;
      5'd12: six_neg = 6'b001101;
      5'd13: six_neg = 6'b101100;
      5'd14: six_neg = 6'b011100;
      5'd15: six_neg = 6'b010111;
      5'd16: six_neg = 6'b011011;
      5'd17: six_neg = 6'b100011;
      5'd18: six_neg = 6'b010011;
      5'd19: six_neg = 6'b110010;
      5'd20: six_neg = 6'b001011;
      5'd21: six_neg = 6'b101010;
      5'd22: six_neg = 6'b011010;
      5'd23: six_neg = 6'b111010;
      5'd24: six_neg = 6'b110011;
      5'd25: six_neg = 6'b100110;
      5'd26: six_neg = 6'b010110;
      5'd27: six_neg = 6'b110110;
      5'd28: six_neg = eff_k ? 6'b001111 : 6'b001110;
      5'd29: six_neg = 6'b101110;
      5'd30: six_neg = 6'b011110;
      5'd31: six_neg = 6'b101011;
      default: six_neg = 6'b000000;
    endcase
  end

  assign six_bal = ($countones(six_neg) == 3);
  // D.7 is balanced but still alternates between 111000 and 000111
  assign six     = (rd_in && (!six_bal || (x == 5'd7))) ? ~six_neg : six_neg;
  assign rd_mid  = rd_in ^ !six_bal;

  assign alt7 = (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

  // 3b/4b codes in their RD- form (fghj), selected by the RD left after the 6b block
  always_comb begin
    four_neg = 4'b0000;
    if (eff_k) begin
      case (y)
        3'd0: four_neg = 4'b1011;
        3'd1: four_neg = 4'b0110;
        3'd2: four_neg = 4'b1010;
        3'd3: four_neg = 4'b1100;
        3'd4: four_neg = 4'b1101;
        3'd5: four_neg = 4'b0101;
        3'd6: four_neg = 4'b1001;
        3'd7: four_neg = 4'b0111;
        default: four_neg = 4'b0000;
      endcase
    end else begin
      case (y)
        3'd0: four_neg = 4'b1011;
        3'd1: four_neg = 4'b1001;
        3'd2: four_neg = 4'b0101;
        3'd3: four_neg = 4'b1100;
        3'd4: four_neg = 4'b1101;
        3'd5: four_neg = 4'b1010;
        3'd6: four_neg = 4'b0110;
        3'd7: four_neg = alt7 ? 4'b0111 : 4'b1110;
        default: four_neg = 4'b0000;
      endcase
    end
  end

  assign four_bal = ($countones(four_neg) == 2);
  // every control 3b/4b alternates; data x.3 alternates despite being balanced
  assign four     = (rd_mid && (eff_k || !four_bal || (y == 3'd3))) ? ~four_neg : four_neg;
  assign rd_out   = rd_mid ^ !four_bal;
  assign code     = {six, four};

endmodule

// File: rtl/enc8b10b_ctrl.sv
// rtl/enc8b10b_ctrl.sv - 8b/10b encode controller: RD ownership, comma fill, post-reset sync burst
// Optional periodic forced commas are compiled in with ENC_ALIGN_EN.
module enc8b10b_ctrl
  import enc8b10b_pkg::*;
#(
  parameter int SYNC_LEN     = 8,
  parameter bit RD_INIT      = 1'b0,
  parameter int ALIGN_PERIOD = 64
) (
  input logic           clk,
  input logic           rst,
  enc8b10b_ctrl_if.slave bus
);

  localparam int SCW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

  state_t         state;
  logic [SCW-1:0] sync_cnt;
  sym_t           out_data_q;
  logic           out_valid_q;
  logic           out_rd_q;
  logic           code_err_q;

  logic       load, take, align_due;
  logic [7:0] enc_data;
  logic       enc_k;
  sym_t       enc_code;
  logic       enc_rd, enc_illegal;

  assign load = !out_valid_q || bus.out_ready;

`ifdef ENC_ALIGN_EN
  localparam int ACW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
  logic [ACW-1:0] sym_cnt;

  assign align_due = (sym_cnt == ACW'(ALIGN_PERIOD - 1));

  // every RUN load counts, idle commas included
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sym_cnt <= '0;
    else if (load && (state == RUN))
      sym_cnt <= align_due ? '0 : sym_cnt + ACW'(1);
  end
`else
  // forced commas are compiled out; this is constant zero
  assign align_due = (ALIGN_PERIOD < 0);
`endif

  assign bus.in_ready = (state == RUN) && load && !align_due;
  assign take         = bus.in_ready && bus.in_valid;
  assign enc_data     = take ? bus.in_data : K28_5;
  assign enc_k        = take ? bus.in_k : 1'b1;

  enc8b10b_sym u_sym (
    .data      (enc_data),
    .k         (enc_k),
    .rd_in     (out_rd_q),
    .code      (enc_code),
    .rd_out    (enc_rd),
    .k_illegal (enc_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      sync_cnt    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= RD_INIT;
      code_err_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= enc_code;
      out_rd_q    <= enc_rd;
      code_err_q  <= enc_illegal;
      if (state == SYNC) begin
        if (sync_cnt == SCW'(SYNC_LEN - 1)) begin
          state    <= RUN;
          sync_cnt <= '0;
        end else begin
          sync_cnt <= sync_cnt + SCW'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.code_err  = code_err_q;

endmodule

// File: tb/tb_enc8b10b_ctrl.sv
// tb/tb_enc8b10b_ctrl.sv - scoreboard bench for enc8b10b_ctrl against a table-driven 8b/10b model
module tb_enc8b10b_ctrl;
  import enc8b10b_pkg::*;

  localparam int SYNC_LEN = 8;
  localparam bit RD_INIT  = 1'b0;
`ifdef ENC_ALIGN_EN
  localparam int AP       = 4;
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam int AP       = 64;
  localparam bit ALIGN_ON = 1'b0;
`endif

  // {RD- code, RD+ code} straight from the standard 5b/6b and 3b/4b tables
  localparam logic [11:0] T6 [32] = '{
    12'b100111_011000, 12'b011101_100010, 12'b101101_010010, 12'b110001_110001,
    12'b110101_001010, 12'b101001_101001, 12'b011001_011001, 12'b111000_000111,
    12'b111001_000110, 12'b100101_100101, 12'b010101_010101, 12'b110100_110100,
    12'b001101_001101, 12'b101100_101100, 12'b011100_011100, 12'b010111_101000,
    12'b011011_100100, 12'b100011_100011, 12'b010011_010011, 12'b110010_110010,
    12'b001011_001011, 12'b101010_101010, 12'b011010_011010, 12'b111010_000101,
    12'b110011_001100, 12'b100110_100110, 12'b010110_010110, 12'b110110_001001,
    12'b001110_001110, 12'b101110_010001, 12'b011110_100001, 12'b101011_010100};
  localparam logic [7:0] T4 [8] = '{
    8'b1011_0100, 8'b1001_1001, 8'b0101_0101, 8'b1100_0011,
    8'b1101_0010, 8'b1010_1010, 8'b0110_0110, 8'b1110_0001};
  localparam logic [7:0] K4 [8] = '{
    8'b1011_0100, 8'b0110_1001, 8'b1010_0101, 8'b1100_0011,
    8'b1101_0010, 8'b0101_1010, 8'b1001_0110, 8'b0111_1000};
  localparam logic [7:0] KL [12] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  typedef struct {
    logic [9:0] code;
    logic       rd;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enc8b10b_ctrl_if bus ();

  enc8b10b_ctrl #(.SYNC_LEN(SYNC_LEN), .RD_INIT(RD_INIT), .ALIGN_PERIOD(AP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int        n_cmp = 0;
  int        n_bad = 0;
  exp_t      sbq[$];
  exp_t      held;
  logic [8:0] dq[$];
  logic      m_rd;
  int        m_loads;
  int        m_cnt;
  bit        acc_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_enc(input logic [7:0] b, input logic k, input logic rd);
    exp_t       e;
    logic [7:0] bb;
    logic [5:0] six;
    logic [3:0] four;
    logic       rdp;
    int         x, y;
    bit         legal;
    legal = 0;
    for (int i = 0; i < 12; i++) if (KL[i] == b) legal = 1;
    bb    = b;
    e.err = 1'b0;
    if (k && !legal) begin
      bb    = 8'hBC;
      e.err = 1'b1;
    end
    x = int'(bb[4:0]);
    y = int'(bb[7:5]);
    if (k && x == 28) six = rd ? 6'b110000 : 6'b001111;
    else              six = rd ? T6[x][5:0] : T6[x][11:6];
    rdp = rd ^ ($countones(six) != 3);
    if (k)
      four = rdp ? K4[y][3:0] : K4[y][7:4];
    else if (y == 7 && ((!rdp && (x == 17 || x == 18 || x == 20)) || (rdp && (x == 11 || x == 13 || x == 14))))
      four = rdp ? 4'b1000 : 4'b0111;
    else
      four = rdp ? T4[y][3:0] : T4[y][7:4];
    e.code = {six, four};
    e.rd   = ($countones(e.code) == 5) ? rd : !rd;
    return e;
  endfunction

  task automatic step(input bit v_en, input bit ordy);
    exp_t e;
    bit   ld, pr;
    @(negedge clk);
    if (!bus.in_valid || acc_last) begin
      if (v_en) begin
        bus.in_valid = 1'b1;
        if (dq.size() != 0) begin
          {bus.in_k, bus.in_data} = dq.pop_front();
        end else if ($urandom_range(0, 7) == 0) begin
          bus.in_k    = 1'b1;
          bus.in_data = ($urandom_range(0, 1) == 0) ? KL[$urandom_range(0, 11)] : 8'($urandom);
        end else begin
          bus.in_k    = 1'b0;
          bus.in_data = 8'($urandom);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = ordy;
    #1;
    ld = !bus.out_valid || ordy;
    pr = (m_loads >= SYNC_LEN) && ld && !(ALIGN_ON && m_cnt == AP - 1);
    chk("in_ready", 32'(bus.in_ready), 32'(pr));
    acc_last = pr && bus.in_valid;
    if (ld) begin
      e    = acc_last ? ref_enc(bus.in_data, bus.in_k, m_rd) : ref_enc(8'hBC, 1'b1, m_rd);
      m_rd = e.rd;
      sbq.push_back(e);
      if (m_loads < SYNC_LEN) m_loads++;
      else if (ALIGN_ON)      m_cnt = (m_cnt == AP - 1) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_rd",    32'(bus.out_rd),    32'(RD_INIT));
    chk("rst_code_err",  32'(bus.code_err),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    reset_checks();
    sbq.delete();
    m_rd     = RD_INIT;
    m_loads  = 0;
    m_cnt    = 0;
    acc_last = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // monitor: every load the driver predicted shows up one edge later
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("out_data",  32'(bus.out_data),  32'(e.code));
        chk("out_rd",    32'(bus.out_rd),    32'(e.rd));
        chk("code_err",  32'(bus.code_err),  32'(e.err));
        held = e;
      end else if (bus.out_valid) begin
        chk("hold_data", 32'(bus.out_data), 32'(held.code));
        chk("hold_rd",   32'(bus.out_rd),   32'(held.rd));
        chk("hold_err",  32'(bus.code_err), 32'(held.err));
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_k      = 1'b0;
    bus.out_ready = 1'b1;
    m_rd          = RD_INIT;
    m_loads       = 0;
    m_cnt         = 0;
    acc_last      = 1'b0;
    #1;
    reset_checks();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // sync burst then idle commas
    repeat (20) step(1'b0, 1'b1);

    // data codes, alternate-7 cases, legal and illegal K requests
    dq.push_back({1'b0, 8'h00}); dq.push_back({1'b0, 8'h00});
    dq.push_back({1'b0, 8'hF1}); dq.push_back({1'b0, 8'hEB});
    dq.push_back({1'b0, 8'hE1}); dq.push_back({1'b0, 8'hEE});
    dq.push_back({1'b0, 8'hF2}); dq.push_back({1'b0, 8'hED});
    dq.push_back({1'b0, 8'h23}); dq.push_back({1'b0, 8'h07});
    dq.push_back({1'b1, 8'h3C}); dq.push_back({1'b1, 8'h00});
    dq.push_back({1'b1, 8'hF7}); dq.push_back({1'b1, 8'hFB});
    dq.push_back({1'b1, 8'hFD}); dq.push_back({1'b1, 8'hFE});
    dq.push_back({1'b1, 8'hFC}); dq.push_back({1'b1, 8'h5A});
    repeat (30) step(1'b1, 1'b1);

    repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // long back-pressure stretch with a byte waiting
    repeat (3) step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);

    do_reset();
    repeat (12) step(1'b1, 1'b1);
    do_reset();
    repeat (20) step(1'b0, 1'b1);
    repeat (200) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    repeat (3) step(1'b0, 1'b1);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
